// File: rtl/cfg_fetch.sv
// Wishbone master: polls CONFIG_DONE, fetches a 32-entry x 3-bit channel table, then writes core-ready.
// Define CFG_FETCH_TIMEOUT_EN to abort any transaction left unanswered for TIMEOUT cycles.
module cfg_fetch #(
  parameter int unsigned POLL_GAP   = 16,
  parameter logic [31:0] DONE_ADDR  = 32'h0000_0080,
  parameter logic [31:0] READY_ADDR = 32'h0000_0084,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] o_wb_adr,
  output logic [3:0]  o_wb_sel,
  output logic        o_wb_we,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [4:0]  ch_sel,
  output logic [2:0]  ch_cfg,
  output logic        cfg_valid,
  output logic        busy,
  output logic        fetch_err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] POLL  = 3'd1;
  localparam logic [2:0] GAP   = 3'd2;
  localparam logic [2:0] FETCH = 3'd3;
  localparam logic [2:0] READY = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERROR = 3'd6;

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  logic [2:0] state;
  logic [4:0] idx;
  logic [7:0] gap_cnt;
  logic [2:0] tbl [32];
  logic       abort;
  logic       unused;

`ifdef CFG_FETCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          timed_out;

  assign timed_out = o_wb_cyc && !i_wb_ack && !i_wb_err && (wait_cnt == TW'(TIMEOUT - 1));
  assign abort     = o_wb_cyc && (i_wb_err || timed_out);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (!o_wb_cyc || i_wb_ack || i_wb_err) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign abort = o_wb_cyc && i_wb_err;
`endif

  assign unused   = ^{1'b0, i_wb_dat[31:3], TIMEOUT[0]};
  assign o_wb_stb = o_wb_cyc;
  assign o_wb_sel = {4{o_wb_cyc}};
  assign ch_cfg   = tbl[ch_sel];
  assign busy     = (state == POLL) || (state == GAP) || (state == FETCH) || (state == READY);

  // FETCH and READY enter with cyc low and launch one cycle later, giving the mandatory idle gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      gap_cnt   <= '0;
      o_wb_adr  <= '0;
      o_wb_we   <= 1'b0;
      o_wb_dat  <= '0;
      o_wb_cyc  <= 1'b0;
      cfg_valid <= 1'b0;
      fetch_err <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) begin
        tbl[i] <= '0;
      end
    end else if (abort) begin
      state     <= ERROR;
      o_wb_cyc  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_adr  <= '0;
      o_wb_dat  <= '0;
      fetch_err <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            state     <= POLL;
            idx       <= '0;
            o_wb_cyc  <= 1'b1;
            o_wb_adr  <= DONE_ADDR;
            o_wb_we   <= 1'b0;
            o_wb_dat  <= '0;
            cfg_valid <= 1'b0;
            fetch_err <= 1'b0;
          end
        end
        POLL: begin
          if (o_wb_cyc && i_wb_ack) begin
            o_wb_cyc <= 1'b0;
            o_wb_adr <= '0;
            if (i_wb_dat[0]) begin
              state <= FETCH;
              idx   <= '0;
            end else begin
              state   <= GAP;
              gap_cnt <= '0;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state    <= POLL;
            o_wb_cyc <= 1'b1;
            o_wb_adr <= DONE_ADDR;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        FETCH: begin
          if (!o_wb_cyc) begin
            o_wb_cyc <= 1'b1;
            o_wb_adr <= {25'd0, idx, 2'b00};
          end else if (i_wb_ack) begin
            tbl[idx] <= i_wb_dat[2:0];
            o_wb_cyc <= 1'b0;
            o_wb_adr <= '0;
            if (idx == 5'd31) begin
              state <= READY;
            end else begin
              idx <= idx + 5'd1;
            end
          end
        end
        READY: begin
          if (!o_wb_cyc) begin
            o_wb_cyc <= 1'b1;
            o_wb_we  <= 1'b1;
            o_wb_adr <= READY_ADDR;
            o_wb_dat <= 32'h0000_0001;
          end else if (i_wb_ack) begin
            state     <= DONE;
            o_wb_cyc  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_adr  <= '0;
            o_wb_dat  <= '0;
            cfg_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_fetch.sv
// Directed bench for cfg_fetch: scripted Wishbone slave, bus-level reference model, transaction log checks.
module tb_cfg_fetch;

  localparam logic [31:0] DONE_A  = 32'h0000_0080;
  localparam logic [31:0] READY_A = 32'h0000_0084;
  localparam int          GAP     = 16;
  localparam int          TMO     = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] o_wb_adr, o_wb_dat, i_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we, o_wb_cyc, o_wb_stb;
  logic        i_wb_ack = 1'b0, i_wb_err = 1'b0;
  logic [4:0]  ch_sel = '0;
  logic [2:0]  ch_cfg;
  logic        cfg_valid, busy, fetch_err;

  always #5 clk = ~clk;

  cfg_fetch #(.POLL_GAP(GAP), .DONE_ADDR(DONE_A), .READY_ADDR(READY_A), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .ch_sel(ch_sel), .ch_cfg(ch_cfg), .cfg_valid(cfg_valid), .busy(busy), .fetch_err(fetch_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave configuration and transaction log
  int nzero = 0, delay = 1, errch = -1, hangch = -1, pat = 0, poll_no = 0, edge_no = 0;
  bit sweep = 1'b1;
  logic [31:0] log_adr[$];
  logic        log_we[$];
  int          rise_t[$];
  int          end_t[$];

  function automatic logic [2:0] patval(input int n);
    return (pat != 0) ? 3'(7 - (n % 8)) : 3'(n % 8);
  endfunction

  task automatic clear_log();
    log_adr.delete(); log_we.delete(); rise_t.delete(); end_t.delete();
    poll_no = 0;
  endtask

  // Scripted slave: responds after `delay` wait cycles, with stray acks while the bus is idle
  initial begin
    int  w, n;
    bit  prev_cyc, prev_resp, is_rd;
    w = 0; prev_cyc = 0; prev_resp = 0;
    forever begin
      @(posedge clk);
      edge_no++;
      #1;
      if (prev_resp) chk("cyc_drop_after_resp", o_wb_cyc, 1'b0);
      prev_resp = 0;
      if (sweep) ch_sel = 5'(edge_no % 32);
      if (o_wb_cyc && !prev_cyc) begin
        log_adr.push_back(o_wb_adr);
        log_we.push_back(o_wb_we);
        rise_t.push_back(edge_no);
        if (o_wb_adr == DONE_A) poll_no++;
        w = 0;
      end
      prev_cyc = o_wb_cyc;
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = $urandom();
      if (o_wb_cyc) begin
        n = int'(o_wb_adr[6:2]);
        is_rd = !o_wb_we && (o_wb_adr < 32'h80);
        if (!(is_rd && n == hangch) && w >= delay) begin
          if (o_wb_adr == DONE_A) i_wb_dat[0] = (poll_no > nzero);
          else if (is_rd) i_wb_dat[2:0] = patval(n);
          i_wb_ack = 1'b1;
          if (is_rd && n == errch) i_wb_err = 1'b1;
          end_t.push_back(edge_no + 1);
          prev_resp = 1;
        end
        w++;
      end else if (edge_no % 7 == 3) begin
        i_wb_ack = 1'b1;
      end
    end
  end

  // Reference model: outcome of each bus cycle as seen at the pins, applied one edge later
  logic [2:0]  m_tbl[32];
  logic        m_valid = 0, m_err = 0, m_busy = 0;
  bit          p_start = 0, p_wr = 0, p_done = 0, p_err = 0;
  logic [4:0]  p_idx;
  logic [2:0]  p_val;
  int          wcnt = 0;
  bit          h_cyc = 0;
  logic [31:0] h_adr, h_dat;
  logic        h_we;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_tbl[i] = 3'd0;
    m_valid = 0; m_err = 0; m_busy = 0;
    p_start = 0; p_wr = 0; p_done = 0; p_err = 0; wcnt = 0; h_cyc = 0;
  endtask

  always @(negedge reset) model_clear();

  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (reset) begin
        if (p_start) begin m_busy = 1; m_valid = 0; m_err = 0; end
        if (p_wr) m_tbl[p_idx] = p_val;
        if (p_done) begin m_valid = 1; m_busy = 0; end
        if (p_err) begin m_err = 1; m_busy = 0; end

        chk("stb_eq_cyc", o_wb_stb, o_wb_cyc);
        chk("sel", o_wb_sel, o_wb_cyc ? 4'hF : 4'h0);
        chk("ch_cfg_model", ch_cfg, m_tbl[ch_sel]);
        chk("cfg_valid_model", cfg_valid, m_valid);
        chk("fetch_err_model", fetch_err, m_err);
        chk("busy_model", busy, m_busy);
        if (o_wb_cyc) begin
          chk("we_only_ready", o_wb_we, o_wb_adr == READY_A);
          if (o_wb_we) chk("wr_data", o_wb_dat, 32'h1);
          if (h_cyc) begin
            chk("hold_adr", o_wb_adr, h_adr);
            chk("hold_we", o_wb_we, h_we);
            chk("hold_dat", o_wb_dat, h_dat);
          end
        end
        h_cyc = o_wb_cyc; h_adr = o_wb_adr; h_we = o_wb_we; h_dat = o_wb_dat;

        p_start = start && !m_busy;
        p_wr = 0; p_done = 0; p_err = 0;
        if (o_wb_cyc) begin
          if (i_wb_err) p_err = 1;
          else if (i_wb_ack) begin
            wcnt = 0;
            if (o_wb_we && o_wb_adr == READY_A) p_done = 1;
            else if (o_wb_adr < 32'h80) begin p_wr = 1; p_idx = o_wb_adr[6:2]; p_val = i_wb_dat[2:0]; end
          end else begin
            wcnt++;
`ifdef CFG_FETCH_TIMEOUT_EN
            if (wcnt == TMO) p_err = 1;
`endif
          end
        end else wcnt = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while ((busy === 1'b1 || k < 2) && k < budget) begin @(posedge clk); #2; k++; end
    chk({name, "_idle_in_time"}, busy, 1'b0);
  endtask

  task automatic read_ch(input string name, input int n, input logic [2:0] exp);
    sweep = 0; ch_sel = 5'(n); #1;
    chk(name, ch_cfg, exp);
  endtask

  task automatic check_log(input string tag, input int nz, input int nreads, input bit wr);
    logic [31:0] ea[$];
    for (int i = 0; i <= nz; i++) ea.push_back(DONE_A);
    for (int n = 0; n < nreads; n++) ea.push_back(32'(4 * n));
    if (wr) ea.push_back(READY_A);
    chk({tag, "_txn_count"}, log_adr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < log_adr.size(); i++) begin
      chk({tag, "_txn_adr"}, log_adr[i], ea[i]);
      chk({tag, "_txn_we"}, log_we[i], ea[i] == READY_A);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_adr"}, o_wb_adr, 0); chk({tag, "_sel"}, o_wb_sel, 0);
    chk({tag, "_we"}, o_wb_we, 0);   chk({tag, "_dat"}, o_wb_dat, 0);
    chk({tag, "_cyc"}, o_wb_cyc, 0); chk({tag, "_stb"}, o_wb_stb, 0);
    chk({tag, "_valid"}, cfg_valid, 0); chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, fetch_err, 0);
  endtask

  initial begin
    int k;
    // Reset state and no traffic before start
    #23; check_all_zero("reset");
    read_ch("reset_tbl13", 13, 3'd0);
    reset = 1'b1; sweep = 1;
    repeat (20) @(posedge clk);
    #2 chk("no_txn_before_start", log_adr.size(), 0);

    // Done at first poll, ack one cycle late, table n mod 8
    clear_log(); nzero = 0; delay = 1; pat = 0;
    pulse_start();
    wait_idle("basic", 3000);
    check_log("basic", 0, 32, 1);
    chk("basic_valid", cfg_valid, 1'b1);
    chk("basic_err", fetch_err, 1'b0);
    read_ch("basic_ch13", 13, 3'd5);
    read_ch("basic_ch31", 31, 3'd7);
    sweep = 1;

    // Restart from DONE: three idle polls, zero-wait slave, ignored start mid-fetch
    clear_log(); nzero = 3; delay = 0; pat = 1;
    pulse_start();
    chk("restart_valid_drop", cfg_valid, 1'b0);
    repeat (100) @(posedge clk);
    #2 chk("midfetch_busy", busy, 1'b1);
    pulse_start();
    wait_idle("gap", 3000);
    check_log("gap", 3, 32, 1);
    if (rise_t.size() == 37 && end_t.size() == 37) begin
      for (int i = 0; i < 3; i++) chk("poll_gap_cycles", rise_t[i + 1] - end_t[i], GAP);
      chk("first_fetch_after_poll", rise_t[4] - end_t[3], 1);
      chk("fetch32_span", end_t[35] - rise_t[4], 63);
      chk("ready_after_fetch", rise_t[36] - end_t[35], 1);
    end else chk("gap_timing_log_len", rise_t.size(), 37);
    read_ch("gap_ch13", 13, 3'd2);
    read_ch("gap_ch0", 0, 3'd7);
    chk("gap_valid", cfg_valid, 1'b1);
    sweep = 1;

    // Error (ack and err together) on channel 7 from a clean table
    @(posedge clk); #2 reset = 1'b0; #5 reset = 1'b1;
    clear_log(); nzero = 0; delay = 1; pat = 0; errch = 7;
    pulse_start();
    wait_idle("err", 3000);
    check_log("err", 0, 8, 0);
    chk("err_flag", fetch_err, 1'b1);
    chk("err_cyc", o_wb_cyc, 1'b0);
    chk("err_valid", cfg_valid, 1'b0);
    read_ch("err_ch6", 6, 3'd6);
    read_ch("err_ch3", 3, 3'd3);
    read_ch("err_ch7", 7, 3'd0);
    sweep = 1; errch = -1;

    // Reset during channel 20 read, then full refetch
    clear_log();
    pulse_start();
    k = 0;
    while (!(o_wb_cyc === 1'b1 && o_wb_adr === 32'd80) && k < 3000) begin @(posedge clk); #3; k++; end
    chk("reached_ch20", o_wb_adr, 32'd80);
    reset = 1'b0; #1;
    check_all_zero("midreset");
    sweep = 0;
    for (int n = 0; n < 32; n++) begin ch_sel = 5'(n); #1 chk("midreset_tbl", ch_cfg, 3'd0); end
    #3 reset = 1'b1; sweep = 1;
    k = log_adr.size();
    repeat (10) @(posedge clk);
    #2 chk("no_txn_after_reset", log_adr.size(), k);
    clear_log();
    pulse_start();
    wait_idle("refetch", 3000);
    check_log("refetch", 0, 32, 1);
    read_ch("refetch_ch20", 20, 3'd4);
    sweep = 1;

    // Slave never answers channel 3
    clear_log(); delay = 0; hangch = 3;
    pulse_start();
`ifdef CFG_FETCH_TIMEOUT_EN
    k = 0;
    while (fetch_err !== 1'b1 && k < 400) begin @(posedge clk); #1; k++; end
    chk("timeout_err", fetch_err, 1'b1);
    chk("timeout_cycles", edge_no - rise_t[rise_t.size() - 1], TMO);
    #1 chk("timeout_cyc_low", o_wb_cyc, 1'b0);
    check_log("timeout", 0, 4, 0);
`else
    k = 0;
    while (!(o_wb_cyc === 1'b1 && o_wb_adr === 32'd12) && k < 400) begin @(posedge clk); #2; k++; end
    chk("hang_reached_ch3", o_wb_adr, 32'd12);
    repeat (1000) @(posedge clk);
    #2 chk("hang_cyc_held", o_wb_cyc, 1'b1);
    chk("hang_adr_held", o_wb_adr, 32'd12);
    chk("hang_no_err", fetch_err, 1'b0);
`endif
    hangch = -1;
    @(posedge clk); #2 reset = 1'b0;
    #3 check_all_zero("final_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_fetch.md
CFG_FETCH -- requirements
Module: cfg_fetch

Interface
REQ-001 Parameter POLL_GAP, 16, idle cycles between CONFIG_DONE polls (range 1..255).
REQ-002 Parameter DONE_ADDR, 32'h0000_0080, Wishbone byte address of the config-done register.
REQ-003 Parameter READY_ADDR, 32'h0000_0084, Wishbone byte address of the core-ready register.
REQ-004 Parameter TIMEOUT, 64, maximum ack wait in cycles (used only under REQ-031).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle pulse that begins a fetch sequence.
REQ-008 o_wb_adr  out  32  Wishbone address.
REQ-009 o_wb_sel  out  4  byte select; 4'hF whenever o_wb_stb is 1, else 0.
REQ-010 o_wb_we  out  1  write enable.
REQ-011 o_wb_dat  out  32  write data.
REQ-012 o_wb_cyc / o_wb_stb  out  1 each  cycle / strobe; always equal.
REQ-013 i_wb_dat  in  32  read data.
REQ-014 i_wb_ack / i_wb_err  in  1 each  slave acknowledge / error.
REQ-015 ch_sel  in  5  channel index for local readback.
REQ-016 ch_cfg  out  3  config of channel ch_sel, combinational from the local table.
REQ-017 cfg_valid  out  1  table complete and core-ready written.
REQ-018 busy  out  1  FSM not in IDLE, DONE or ERROR.
REQ-019 fetch_err  out  1  sequence aborted.

Function
REQ-020 FSM states SHALL be IDLE, POLL, GAP, FETCH, READY, DONE, ERROR.
REQ-021 IDLE/DONE/ERROR + start=1 -> POLL; cfg_valid and fetch_err clear on the same edge; start is ignored in any other state.
REQ-022 Each transaction: adr/we/dat/cyc/stb driven on the edge entering the state and held unchanged until the edge on which ack or err is sampled high; cyc/stb are 0 for at least one cycle between transactions.
REQ-023 POLL: read DONE_ADDR; on ack with i_wb_dat[0]=1 -> FETCH with index 0; with i_wb_dat[0]=0 -> GAP.
REQ-024 GAP: count POLL_GAP cycles with cyc=0, then -> POLL.
REQ-025 FETCH: read address 4*index; on ack store i_wb_dat[2:0] to table[index] on that edge; index 31 -> READY, else index+1 and next read.
REQ-026 READY: write 32'h0000_0001 to READY_ADDR with we=1; on ack -> DONE, cfg_valid=1 on that edge.
REQ-027 i_wb_err sampled high in any transaction -> ERROR, cyc/stb/we=0 on that edge, fetch_err=1; table retains entries already written.
REQ-028 ack and err high together SHALL be treated as err.
REQ-029 Ack sampled while cyc=0 SHALL be ignored.
REQ-030 Zero-wait slave (ack in first cycle): 32 reads complete in 64 cycles minimum, READY write immediately after.

Configuration
REQ-031 With CFG_FETCH_TIMEOUT_EN defined, a counter SHALL abort any transaction not acked/erred within TIMEOUT cycles of cyc rising, taking the REQ-027 path; without it the FSM waits indefinitely and no counter is synthesised.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, index 0, o_wb_adr/sel/we/dat/cyc/stb=0, cfg_valid=0, busy=0, fetch_err=0, all table entries 3'b000, including mid-transaction.
REQ-033 After reset deassertion no transaction SHALL start until a start pulse.

Verification
REQ-034 Done reg=1 at first poll, table ch n = n mod 8, ack 1 cycle late -> 32 reads at 4*n, write 1 to READY_ADDR, cfg_valid=1, ch_sel=13 gives ch_cfg=5.
REQ-035 Done reg=0 for 3 polls then 1, POLL_GAP=16 -> exactly 4 reads of DONE_ADDR, 16 idle cycles between each, then normal fetch.
REQ-036 i_wb_err on channel 7 read -> ERROR, fetch_err=1, cyc=0 next cycle, ch_cfg for channels 0..6 correct, channel 7 = 0.
REQ-037 reset asserted during channel 20 read -> all Wishbone outputs 0 without clock edge, table 0; new start refetches all 32.
REQ-038 CFG_FETCH_TIMEOUT_EN, TIMEOUT=64, slave never acks channel 3 -> fetch_err=1 exactly 64 cycles after cyc rise; without macro cyc stays 1 for 1000 cycles.
REQ-039 start pulse during FETCH -> ignored, sequence unchanged; start in DONE -> cfg_valid drops, full refetch.
